// File: rtl/sprite_blit_pkg.sv
// Shared types and constants for the sprite blitter. The optional horizontal flip is
// guarded by SPRITE_BLIT_MIRROR_EN.
package sprite_blit_pkg;

  localparam int FB_WIDTH_C    = 226;
  localparam int FB_HEIGHT_C   = 248;
  localparam int SPRITE_W_C    = 16;
  localparam int SPRITE_H_C    = 16;
  localparam int NUM_SPRITES_C = 8;
  localparam int ADDR_W_C      = 20;
  localparam int SPR_BITS_C    = $clog2(NUM_SPRITES_C);
  localparam int ROW_BITS_C    = $clog2(SPRITE_H_C);
  localparam int COL_BITS_C    = $clog2(SPRITE_W_C);
  localparam int ROM_AW_C      = SPR_BITS_C + ROW_BITS_C + COL_BITS_C;
  localparam logic [15:0] TRANSPARENT_C = 16'h0000;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    CHECK,
    WAIT_BLANK,
    WRITE,
    NEXT,
    DONE
  } blit_state_t;

  typedef struct packed {
    logic [SPR_BITS_C-1:0] sprite;
    logic [9:0]            x;
    logic [9:0]            y;
`ifdef SPRITE_BLIT_MIRROR_EN
    logic                  mirror;
`endif
  } blit_cmd_t;

  // Built-in sprite image, addressed {sprite, row, col}; stands in for the hex image.
  function automatic logic [15:0] rom_pixel(input logic [ROM_AW_C-1:0] a);
    logic [SPR_BITS_C-1:0] s;
    logic [ROW_BITS_C-1:0] r;
    logic [COL_BITS_C-1:0] c;
    logic [15:0]           p;
    s = a[ROM_AW_C-1 -: SPR_BITS_C];
    r = a[COL_BITS_C +: ROW_BITS_C];
    c = a[COL_BITS_C-1:0];
    case (s)
      3'd0:    p = 16'h0005;
      3'd1:    p = (r == c) ? (16'h0010 + {12'h000, r}) : TRANSPARENT_C;
      3'd2:    p = (r == 4'd0 && c == 4'd0) ? 16'h0003 : TRANSPARENT_C;
      3'd3:    p = {8'h30, r, c};
      default: p = (r[0] ^ c[0]) ? {4'h7, 1'b0, s, r, c} : TRANSPARENT_C;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/sprite_blit_engine_rom.sv
// Sprite pixel ROM: synchronous read, one cycle of latency.
module sprite_blit_engine_rom
  import sprite_blit_pkg::*;
(
  input  logic                clk,
  input  logic [ROM_AW_C-1:0] addr,
  output logic [15:0]         data
);

  always_ff @(posedge clk) begin
    data <= rom_pixel(addr);
  end

endmodule

// File: rtl/sprite_blit_engine.sv
// Sprite blitter: copies non-transparent, on-screen sprite pixels into the frame buffer
// during VGA blanking. Optional horizontal flip via SPRITE_BLIT_MIRROR_EN.
//
// state      | meaning
// IDLE       | ready for a command
// FETCH      | ROM address for (row, col) presented
// CHECK      | ROM data back; transparency / clip test, latch write
// WAIT_BLANK | pixel pending, waiting for blank_n=0
// WRITE      | wr_req_n low until sram_ready or blanking ends
// NEXT       | advance col/row
// DONE       | one-cycle done pulse
module sprite_blit_engine
  import sprite_blit_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [SPR_BITS_C-1:0] cmd_sprite,
  input  logic [9:0]            cmd_x,
  input  logic [9:0]            cmd_y,
`ifdef SPRITE_BLIT_MIRROR_EN
  input  logic                  cmd_mirror,
`endif
  input  logic                  blank_n,
  output logic                  wr_req_n,
  output logic [ADDR_W_C-1:0]   wr_addr,
  output logic [15:0]           wr_data,
  input  logic                  sram_ready,
  output logic                  busy,
  output logic                  done
);

  blit_state_t           state;
  blit_cmd_t             cmd;
  blit_cmd_t             next_cmd;
  logic [ROW_BITS_C-1:0] row;
  logic [COL_BITS_C-1:0] col;
  logic [COL_BITS_C-1:0] rom_col;
  logic [ROM_AW_C-1:0]   rom_addr;
  logic [15:0]           rom_data;
  logic [10:0]           px;
  logic [10:0]           py;
  logic [ADDR_W_C-1:0]   lin_addr;
  logic                  skip;

  always_comb begin
    next_cmd        = '0;
    next_cmd.sprite = cmd_sprite;
    next_cmd.x      = cmd_x;
    next_cmd.y      = cmd_y;
`ifdef SPRITE_BLIT_MIRROR_EN
    next_cmd.mirror = cmd_mirror;
`endif
  end

`ifdef SPRITE_BLIT_MIRROR_EN
  // Flip reads the ROM right-to-left; the destination column is unchanged.
  assign rom_col = col ^ {COL_BITS_C{cmd.mirror}};
`else
  assign rom_col = col;
`endif

  assign rom_addr = {cmd.sprite, row, rom_col};

  sprite_blit_engine_rom u_rom (
    .clk  (clk),
    .addr (rom_addr),
    .data (rom_data)
  );

  // 11-bit sums so positions past 1023 clip instead of wrapping back on screen.
  assign px       = {1'b0, cmd.x} + {7'b0, col};
  assign py       = {1'b0, cmd.y} + {7'b0, row};
  assign lin_addr = ADDR_W_C'(py) * ADDR_W_C'(FB_WIDTH_C) + ADDR_W_C'(px);
  assign skip     = (rom_data == TRANSPARENT_C) || (px >= 11'(FB_WIDTH_C)) ||
                    (py >= 11'(FB_HEIGHT_C));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cmd       <= '0;
      row       <= '0;
      col       <= '0;
      cmd_ready <= 1'b1;
      wr_req_n  <= 1'b1;
      wr_addr   <= '0;
      wr_data   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd       <= next_cmd;
            row       <= '0;
            col       <= '0;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= FETCH;
          end
        end
        FETCH: state <= CHECK;
        CHECK: begin
          if (skip) begin
            state <= NEXT;
          end else begin
            wr_addr <= lin_addr;
            wr_data <= rom_data;
            state   <= WAIT_BLANK;
          end
        end
        WAIT_BLANK: begin
          if (!blank_n) begin
            wr_req_n <= 1'b0;
            state    <= WRITE;
          end
        end
        WRITE: begin
          // Completion wins over blanking ending in the same cycle.
          if (sram_ready) begin
            wr_req_n <= 1'b1;
            state    <= NEXT;
          end else if (blank_n) begin
            wr_req_n <= 1'b1;
            state    <= WAIT_BLANK;
          end
        end
        NEXT: begin
          col <= col + 1'b1;
          if (col == COL_BITS_C'(SPRITE_W_C - 1)) begin
            if (row == ROW_BITS_C'(SPRITE_H_C - 1)) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= DONE;
            end else begin
              row   <= row + 1'b1;
              state <= FETCH;
            end
          end else begin
            state <= FETCH;
          end
        end
        DONE: begin
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_blit_engine.sv
// Directed bench for sprite_blit_engine: scoreboard of expected SRAM writes checked at
// each write completion. Covers the mirror case when SPRITE_BLIT_MIRROR_EN is defined.
module tb_sprite_blit_engine;

  localparam int FB_W    = 226;
  localparam int FB_H    = 248;
  localparam int FB_SIZE = FB_W * FB_H;

  typedef struct {
    logic [19:0] addr;
    logic [15:0] data;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_sprite;
  logic [9:0]  cmd_x;
  logic [9:0]  cmd_y;
  logic        cmd_mirror;
  logic        blank_n;
  logic        wr_req_n;
  logic [19:0] wr_addr;
  logic [15:0] wr_data;
  logic        sram_ready;
  logic        busy;
  logic        done;

  int          checks;
  int          errors;
  exp_t        exp_q[$];
  int          sram_lat;
  logic        sram_hold;
  int          wr_count;
  logic [19:0] first_addr;
  logic [19:0] last_addr;

  sprite_blit_engine dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_sprite (cmd_sprite),
    .cmd_x      (cmd_x),
    .cmd_y      (cmd_y),
`ifdef SPRITE_BLIT_MIRROR_EN
    .cmd_mirror (cmd_mirror),
`endif
    .blank_n    (blank_n),
    .wr_req_n   (wr_req_n),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .sram_ready (sram_ready),
    .busy       (busy),
    .done       (done)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_pix(input int s, input int r, input int c);
    case (s)
      0:       return 16'h0005;
      1:       return (r == c) ? 16'(16 + r) : 16'h0000;
      2:       return (r == 0 && c == 0) ? 16'h0003 : 16'h0000;
      3:       return 16'(16'h3000 + r * 16 + c);
      default: return ((r + c) % 2 == 1) ? 16'(16'h7000 + s * 256 + r * 16 + c) : 16'h0000;
    endcase
  endfunction

  task automatic push_expected(input int s, input int x, input int y, input bit m);
    exp_t e;
    for (int r = 0; r < 16; r++) begin
      for (int c = 0; c < 16; c++) begin
        logic [15:0] p;
        p = ref_pix(s, r, m ? 15 - c : c);
        if (p != 16'h0000 && (x + c) < FB_W && (y + r) < FB_H) begin
          e.addr = 20'((y + r) * FB_W + x + c);
          e.data = p;
          exp_q.push_back(e);
        end
      end
    end
  endtask

  task automatic start_blit(input int s, input int x, input int y, input bit m);
    int n;
    n = 0;
    while (!cmd_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready_wait", cmd_ready, 1);
    push_expected(s, x, y, m);
    wr_count   = 0;
    cmd_sprite = 3'(s);
    cmd_x      = 10'(x);
    cmd_y      = 10'(y);
    cmd_mirror = m;
    cmd_valid  = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("busy_after_accept", busy, 1);
    check("ready_after_accept", cmd_ready, 0);
  endtask

  task automatic finish_blit(input int exp_writes);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 20000);
    check("done_seen", done, 1);
    check("busy_at_done", busy, 0);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("ready_after_done", cmd_ready, 1);
    check("queue_drained", exp_q.size(), 0);
    check("write_count", wr_count, exp_writes);
  endtask

  // SRAM model: completes each request sram_lat cycles after wr_req_n falls.
  initial begin
    int   cnt;
    exp_t e;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (!wr_req_n && !sram_hold && reset_n) begin
        cnt++;
        if (cnt == sram_lat) begin
          sram_ready = 1'b1;
          check("write_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("wr_addr", wr_addr, e.addr);
            check("wr_data", wr_data, e.data);
          end
          check("addr_in_fb", wr_addr < 20'(FB_SIZE), 1);
          check("no_write_in_active", blank_n, 0);
          if (wr_count == 0) first_addr = wr_addr;
          last_addr = wr_addr;
          wr_count++;
        end else begin
          sram_ready = 1'b0;
        end
      end else begin
        cnt        = 0;
        sram_ready = 1'b0;
      end
    end
  end

  initial begin
    int n;
    checks     = 0;
    errors     = 0;
    sram_lat   = 2;
    sram_hold  = 1'b0;
    sram_ready = 1'b0;
    wr_count   = 0;
    first_addr = '0;
    last_addr  = '0;
    cmd_valid  = 1'b0;
    cmd_sprite = '0;
    cmd_x      = '0;
    cmd_y      = '0;
    cmd_mirror = 1'b0;
    blank_n    = 1'b0;
    reset_n    = 1'b1;
    #5 reset_n = 1'b0;
    #5;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_wr_req_n", wr_req_n, 1);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Full sprite, every pixel written.
    start_blit(0, 10, 20, 1'b0);
    finish_blit(256);
    check("first_addr", first_addr, 4530);
    check("last_addr", last_addr, 7935);

    // Diagonal sprite: 16 writes stepping by FB_W+1.
    start_blit(1, 3, 7, 1'b0);
    finish_blit(16);

    // Clipped at bottom-right corner.
    start_blit(0, 220, 240, 1'b0);
    finish_blit(48);

    // Far off-screen: 11-bit sums must clip, not wrap.
    start_blit(3, 1020, 1020, 1'b0);
    finish_blit(0);

    // Last visible row/column reached, slower SRAM.
    sram_lat = 3;
    start_blit(3, 210, 232, 1'b0);
    finish_blit(256);
    check("last_addr_edge", last_addr, FB_SIZE - 1);

    sram_lat = 1;
    start_blit(5, 100, 60, 1'b0);
    finish_blit(128);
    sram_lat = 2;

    // Blanking ends with a write pending: request drops, same pixel retried.
    sram_hold = 1'b1;
    start_blit(1, 0, 0, 1'b0);
    n = 0;
    while (wr_req_n && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("req_low", wr_req_n, 0);
    check("req_addr", wr_addr, 0);
    check("req_data", wr_data, 16'h0010);
    blank_n = 1'b1;
    @(negedge clk);
    check("req_drop_on_active", wr_req_n, 1);
    repeat (5) @(negedge clk);
    check("req_held_off", wr_req_n, 1);
    check("addr_held", wr_addr, 0);
    blank_n = 1'b0;
    @(negedge clk);
    check("req_reissued", wr_req_n, 0);
    check("reissue_addr", wr_addr, 0);
    check("reissue_data", wr_data, 16'h0010);
    sram_hold = 1'b0;
    finish_blit(16);

    // Asynchronous reset mid-blit, then immediate new command.
    start_blit(0, 0, 0, 1'b0);
    repeat (100) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_cmd_ready", cmd_ready, 1);
    check("mid_rst_wr_req_n", wr_req_n, 1);
    check("mid_rst_wr_addr", wr_addr, 0);
    check("mid_rst_wr_data", wr_data, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    push_expected(2, 100, 50, 1'b0);
    wr_count   = 0;
    cmd_sprite = 3'd2;
    cmd_x      = 10'd100;
    cmd_y      = 10'd50;
    cmd_mirror = 1'b0;
    cmd_valid  = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("accept_after_rst", busy, 1);
    finish_blit(1);
    check("single_write_addr", last_addr, 50 * FB_W + 100);

`ifdef SPRITE_BLIT_MIRROR_EN
    start_blit(2, 30, 40, 1'b1);
    finish_blit(1);
    check("mirror_addr", last_addr, 40 * FB_W + 45);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprite_blit_engine.md
Name: sprite_blit_engine

Overview:
Draw-side producer for the SRAM frame buffer; sits directly upstream of sram_ctrl as its write-port client.
- Accepts one blit command at a time: sprite id plus top-left (x, y).
- Reads sprite pixels from an on-chip sprite ROM and writes every non-transparent, on-screen pixel into SRAM.
- Issues writes only while the VGA is blanking, so it never collides with the scan-out reads.

Parameters:
FB_WIDTH, 226, frame-buffer row pitch in pixels; address = Y*FB_WIDTH + X
FB_HEIGHT, 248, visible frame-buffer rows
SPRITE_W, 16, sprite width in pixels
SPRITE_H, 16, sprite height in pixels
NUM_SPRITES, 8, sprites held in ROM
ADDR_W, 20, SRAM address width
TRANSPARENT, 16'h0000, colour index that is skipped, not written

Ports:
clk  in  1  system clock (50 MHz)
reset_n  in  1  asynchronous active-low reset
cmd_valid  in  1  blit command present
cmd_ready  out  1  engine can accept a command
cmd_sprite  in  $clog2(NUM_SPRITES)  sprite id
cmd_x  in  10  top-left X, frame-buffer pixels
cmd_y  in  10  top-left Y
blank_n  in  1  VGA_BLANK_N; writes may start only while 0
wr_req_n  out  1  active-low write request to sram_ctrl
wr_addr  out  ADDR_W  SRAM write address
wr_data  out  16  colour index to write
sram_ready  in  1  one-cycle pulse, current SRAM access complete
busy  out  1  blit in progress
done  out  1  one-cycle pulse, blit finished

Behaviour:
Reset (async, any state):
- Outputs: cmd_ready=1, wr_req_n=1, wr_addr=0, wr_data=0, busy=0, done=0.
- State returns to IDLE. A blit interrupted by reset is abandoned; pixels already written stay in SRAM.

Command acceptance and counters:
- A command is accepted on the cycle cmd_valid && cmd_ready. The fields are latched and row and col are cleared to 0.
- On acceptance: cmd_ready=0 and busy=1 from the next cycle.

States:
- IDLE: cmd_ready=1. Accept command -> FETCH.
- FETCH: drive ROM address = sprite*SPRITE_W*SPRITE_H + row*SPRITE_W + col. ROM latency is 1 cycle. -> CHECK.
- CHECK: the pixel is skipped (-> NEXT) if the ROM data equals TRANSPARENT, or if px=x+col >= FB_WIDTH, or if py=y+row >= FB_HEIGHT. px and py are computed at 11 bits, so a sum above 1023 clips rather than wrapping. Otherwise latch wr_addr = py*FB_WIDTH + px (ADDR_W bits) and wr_data = the ROM data -> WAIT_BLANK.
- WAIT_BLANK: wr_req_n=1. When blank_n=0 -> WRITE.
- WRITE: wr_req_n=0; wr_addr and wr_data are held stable.
  - sram_ready=1 -> wr_req_n=1, go to NEXT.
  - blank_n=1 before sram_ready -> wr_req_n=1, go to WAIT_BLANK; the same pixel is retried at the next blanking interval.
  - sram_ready and blank_n rising in the same cycle count as completion.
- NEXT: col+1. At col=SPRITE_W-1, col=0 and row+1. After the pixel at row=SPRITE_H-1, col=SPRITE_W-1 -> DONE; otherwise -> FETCH.
- DONE: done=1 for one cycle, busy=0 -> IDLE. cmd_ready=1 from the following cycle.

Handshake rules:
- At most one outstanding write.
- wr_req_n never goes low while blank_n=1.
- A cmd_valid arriving while busy is ignored and is not queued; the producer holds it until cmd_ready.

Throughput: 3 cycles per skipped pixel; 4 cycles plus the SRAM latency per written pixel.

Optional Feature:
SPRITE_BLIT_MIRROR_EN
- Defined: adds input cmd_mirror (1 bit), latched with the command. When set, the ROM column index is SPRITE_W-1-col while the destination X stays x+col, giving a horizontal flip (left/right facing sprites).
- Not defined: the port is absent and the ROM column is always col.

Decomposition:
Shared package sprite_blit_pkg:
- typedef blit_state_t {IDLE, FETCH, CHECK, WAIT_BLANK, WRITE, NEXT, DONE}
- typedef blit_cmd_t struct {sprite, x, y[, mirror]}
- constants FB_WIDTH_C, FB_HEIGHT_C, TRANSPARENT_C.

One sub-module, sprite_rom: synchronous read, 1-cycle latency, contents initialised from a hex file.

Test Plan:
- Sprite 0 filled with 16'h0005, cmd (0,10,20), blank_n held 0, sram_ready 2 cycles after each request -> 256 writes; first wr_addr=20*226+10=4530, last wr_addr=35*226+25=7935; one done pulse.
- Sprite with only its diagonal non-zero -> exactly 16 writes, at addresses y*226+x+k*227 for k=0..15.
- cmd_x=220, cmd_y=240 -> only cols 0..5 and rows 0..7 are written (48 writes); no address ever reaches or exceeds 248*226.
- blank_n toggled 1 while WRITE is pending, sram_ready withheld -> wr_req_n rises the same cycle; the same addr/data are reissued at the next blank_n=0; no pixel is lost or duplicated.
- reset_n pulsed low mid-blit -> outputs return to their reset values asynchronously; a new command is accepted on the first cycle after reset release.
- With SPRITE_BLIT_MIRROR_EN and cmd_mirror=1, sprite whose ROM col 0 is 16'h0003 and other cols are 0 -> a single write at x+15.
